pwm_timebase: RTL and testbench
===============================

PWM_TIMEBASE -- requirements
Module: pwm_timebase

Interface
REQ-001 Parameter WIDTH, default 16: width of the counter, period and duty.
REQ-002 Parameter PRESC_WIDTH, default 8: width of the prescaler.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low; synchronous deassert is the integrator's responsibility.
REQ-005 enable  input  1  run request; low = stopped.
REQ-006 period_in  input  WIDTH  requested period; the counter counts 0..period inclusive.
REQ-007 duty_in  input  WIDTH  requested duty compare value.
REQ-008 prescale_in  input  PRESC_WIDTH  requested prescale; the counter advances once every prescale+1 clocks.
REQ-009 load  input  1  single-cycle strobe that captures period_in, duty_in and prescale_in into the pending registers.
REQ-010 counter_value  output  WIDTH  running count; drives the downstream comparator.
REQ-011 duty  output  WIDTH  active duty; drives the downstream comparator.
REQ-012 pwm_en  output  1  high in RUN; drives the comparator enable.
REQ-013 period_end  output  1  single-cycle pulse on each counter wrap.
REQ-014 update_ack  output  1  single-cycle pulse when pending values become active.
REQ-015 pending  output  1  high while captured values await application.

Function
REQ-016 The block SHALL have two states, IDLE and RUN; IDLE->RUN when enable=1; RUN->IDLE when enable=0, with no wait for a period boundary.
REQ-017 In IDLE, counter_value and the prescaler count SHALL be 0, pwm_en=0, and period_end=0.
REQ-018 In RUN, the prescaler SHALL count 0..prescale_active; a tick SHALL occur in the cycle the prescaler equals prescale_active, and the prescaler SHALL then return to 0.
REQ-019 On a tick with counter_value<period_active, the counter SHALL increment by 1.
REQ-020 On a tick with counter_value>=period_active, the counter SHALL wrap to 0 and period_end SHALL assert for exactly the next cycle.
REQ-021 With period_active=0, the counter SHALL remain 0 and period_end SHALL pulse on every tick.
REQ-022 With prescale_active=0, every RUN cycle SHALL be a tick.
REQ-023 load SHALL copy period_in, duty_in and prescale_in into the pending registers and set pending=1 on the next edge.
REQ-024 A later load while pending=1 SHALL overwrite the pending values; only the latest load is applied.
REQ-025 In RUN, pending values SHALL transfer to the active registers on the same edge as a wrap; pending SHALL then clear and update_ack SHALL pulse for one cycle.
REQ-026 In IDLE, pending values SHALL transfer on the edge after capture, with update_ack pulsing, so the first period after enable uses them.
REQ-027 If load coincides with a wrap edge, the previously pending values (if any) SHALL apply at that wrap, and the newly loaded values SHALL become pending for the next wrap.
REQ-028 The duty output SHALL change only on a wrap edge or in IDLE, so the downstream comparator never sees a mid-period duty change.
REQ-029 duty_active>period_active is legal: the block passes it through unchanged, giving 100% output downstream.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 While rst_n=0: state=IDLE; counter_value=0; the prescaler=0; period_active=all-ones; duty=0; prescale_active=0; pending=0; period_end=0; update_ack=0; pwm_en=0.
REQ-032 Reset asserted mid-period SHALL clear all state immediately and discard pending values.

Verification
REQ-033 Reset, then load period=4, duty=2, prescale=0, then enable=1 -> counter_value sequence 0,1,2,3,4,0; period_end pulses once per 5 clocks; duty=2.
REQ-034 prescale=2, period=1 -> each count value is held 3 clocks; period_end pulses every 6 clocks.
REQ-035 Running period=9; load period=3, duty=1 at count 5 -> pending=1; counter reaches 9, then wraps; update_ack coincides with the wrap; the next period counts 0..3.
REQ-036 Running period=9; load at the wrap edge -> the new values apply at the following wrap, not the current one.
REQ-037 Running with period=0 -> counter_value stays 0; period_end is high every tick.
REQ-038 Running with period=9; enable dropped at count 6 -> counter_value=0 and pwm_en=0 the next cycle; rst_n pulsed low mid-run -> all outputs reach reset values asynchronously.

Source files
------------

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaled up-counter with double-buffered period/duty/prescale that only
// take effect at a period wrap (or immediately while stopped).
module pwm_timebase #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned PRESC_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [WIDTH-1:0]       period_in,
  input  logic [WIDTH-1:0]       duty_in,
  input  logic [PRESC_WIDTH-1:0] prescale_in,
  input  logic                   load,
  output logic [WIDTH-1:0]       counter_value,
  output logic [WIDTH-1:0]       duty,
  output logic                   pwm_en,
  output logic                   period_end,
  output logic                   update_ack,
  output logic                   pending
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                 r_state;
  logic [WIDTH-1:0]       r_count;
  logic [PRESC_WIDTH-1:0] r_presc;
  logic [WIDTH-1:0]       r_period_act;
  logic [WIDTH-1:0]       r_duty_act;
  logic [PRESC_WIDTH-1:0] r_presc_act;
  logic [WIDTH-1:0]       r_period_pend;
  logic [WIDTH-1:0]       r_duty_pend;
  logic [PRESC_WIDTH-1:0] r_presc_pend;
  logic                   r_pending;
  logic                   r_period_end;
  logic                   r_update_ack;
  logic                   r_pwm_en;

  logic w_running;
  logic w_tick;
  logic w_wrap;
  logic w_apply;

  // Dropping enable stops counting on this edge, without waiting for a boundary.
  assign w_running = (r_state == StRun) && enable;
  assign w_tick    = w_running && (r_presc == r_presc_act);
  assign w_wrap    = w_tick && (r_count >= r_period_act);
  // While stopped there is no period to protect, so pending values apply at once.
  assign w_apply   = r_pending && ((r_state == StIdle) || w_wrap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_count       <= '0;
      r_presc       <= '0;
      r_period_act  <= '1;
      r_duty_act    <= '0;
      r_presc_act   <= '0;
      r_period_pend <= '0;
      r_duty_pend   <= '0;
      r_presc_pend  <= '0;
      r_pending     <= 1'b0;
      r_period_end  <= 1'b0;
      r_update_ack  <= 1'b0;
      r_pwm_en      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (enable) begin
            r_state  <= StRun;
            r_pwm_en <= 1'b1;
          end
        end
        StRun: begin
          if (!enable) begin
            r_state  <= StIdle;
            r_pwm_en <= 1'b0;
          end
        end
        default: begin
          r_state  <= StIdle;
          r_pwm_en <= 1'b0;
        end
      endcase

      if (!w_running) begin
        r_count <= '0;
        r_presc <= '0;
      end else if (w_tick) begin
        r_presc <= '0;
        r_count <= w_wrap ? '0 : r_count + WIDTH'(1);
      end else begin
        r_presc <= r_presc + PRESC_WIDTH'(1);
      end

      r_period_end <= w_wrap;
      r_update_ack <= w_apply;

      if (w_apply) begin
        r_period_act <= r_period_pend;
        r_duty_act   <= r_duty_pend;
        r_presc_act  <= r_presc_pend;
      end

      // A load on an apply edge refills the buffer for the following wrap.
      if (load) begin
        r_period_pend <= period_in;
        r_duty_pend   <= duty_in;
        r_presc_pend  <= prescale_in;
      end
      r_pending <= load || (r_pending && !w_apply);
    end
  end

  assign counter_value = r_count;
  assign duty          = r_duty_act;
  assign pwm_en        = r_pwm_en;
  assign period_end    = r_period_end;
  assign update_ack    = r_update_ack;
  assign pending       = r_pending;

endmodule

// File: tb/tb_pwm_timebase.sv
// Bench for pwm_timebase: directed scenarios plus random traffic against a phase-based model.
module tb_pwm_timebase;

  localparam int unsigned W  = 16;
  localparam int unsigned PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  period_in = '0;
  logic [W-1:0]  duty_in = '0;
  logic [PW-1:0] prescale_in = '0;
  logic [W-1:0]  counter_value;
  logic [W-1:0]  duty;
  logic          pwm_en;
  logic          period_end;
  logic          update_ack;
  logic          pending;

  pwm_timebase #(.WIDTH(W), .PRESC_WIDTH(PW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .period_in    (period_in),
    .duty_in      (duty_in),
    .prescale_in  (prescale_in),
    .load         (load),
    .counter_value(counter_value),
    .duty         (duty),
    .pwm_en       (pwm_en),
    .period_end   (period_end),
    .update_ack   (update_ack),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Model: m_phase is clocks elapsed in the current period; count = phase / (prescale+1).
  bit                m_run;
  longint unsigned   m_phase;
  int unsigned       a_period, a_duty, a_presc;
  int unsigned       p_period, p_duty, p_presc;
  bit                m_pending, m_pe, m_ack;

  function automatic void model_reset();
    m_run = 0; m_phase = 0;
    a_period = 32'hFFFF; a_duty = 0; a_presc = 0;
    m_pending = 0; m_pe = 0; m_ack = 0;
  endfunction

  function automatic longint unsigned period_len();
    return (longint'(a_period) + 1) * (longint'(a_presc) + 1);
  endfunction

  function automatic int unsigned exp_count();
    return m_run ? int'(m_phase / (longint'(a_presc) + 1)) : 0;
  endfunction

  function automatic bit wrap_next();
    return m_run && enable && (m_phase == period_len() - 1);
  endfunction

  function automatic void model_edge();
    bit running, wrap, apply;
    running = m_run && enable;
    wrap    = running && (m_phase == period_len() - 1);
    apply   = m_pending && (!m_run || wrap);
    m_pe    = wrap;
    m_ack   = apply;
    if (!running || wrap) m_phase = 0;
    else m_phase++;
    if (apply) begin
      a_period = p_period; a_duty = p_duty; a_presc = p_presc;
    end
    if (load) begin
      p_period = period_in; p_duty = duty_in; p_presc = prescale_in;
    end
    m_pending = load || (m_pending && !apply);
    m_run = enable;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("counter_value", counter_value, exp_count());
    check("duty", duty, a_duty);
    check("pwm_en", pwm_en, m_run);
    check("period_end", period_end, m_pe);
    check("update_ack", update_ack, m_ack);
    check("pending", pending, m_pending);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_load(input int unsigned p, input int unsigned d, input int unsigned s);
    period_in = W'(p); duty_in = W'(d); prescale_in = PW'(s); load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 rst_n = 1'b1;
  endtask

  task automatic run_to_count(input int unsigned c);
    for (int i = 0; i < 400 && exp_count() != c; i++) step();
  endtask

  int unsigned seq033 [6] = '{0, 1, 2, 3, 4, 0};

  initial begin
    model_reset();
    #2;
    check_all();
    #10 rst_n = 1'b1;

    // Period 4, no prescale: 0,1,2,3,4,0 with a wrap pulse on the return to 0.
    do_load(4, 2, 0);
    step();
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("seq033", counter_value, seq033[i]);
    end
    check("pe033", period_end, 1);
    check("duty033", duty, 2);
    run(10);

    // Prescale 2, period 1.
    enable = 1'b0;
    step();
    do_load(1, 1, 2);
    step();
    enable = 1'b1;
    run(14);

    // Period 9, then reload period 3 at count 5.
    enable = 1'b0;
    step();
    do_load(9, 5, 0);
    step();
    enable = 1'b1;
    run_to_count(5);
    do_load(3, 1, 0);
    check("pend035", pending, 1);
    run(20);

    // Load landing exactly on a wrap edge applies one wrap later.
    do_load(9, 4, 0);
    run(12);
    for (int i = 0; i < 400 && !wrap_next(); i++) step();
    do_load(6, 3, 0);
    check("pend036", pending, 1);
    run(20);

    // Period 0: counter stuck at 0, wrap pulse every tick.
    do_load(0, 0, 0);
    run(12);

    // Enable drop at count 6, then asynchronous reset mid-run.
    do_load(9, 4, 0);
    run(3);
    run_to_count(6);
    enable = 1'b0;
    step();
    check("cnt038", counter_value, 0);
    check("en038", pwm_en, 0);
    enable = 1'b1;
    run(7);
    do_load(2, 1, 1);
    mid_reset();
    run(5);

    // Random traffic.
    repeat (800) begin
      enable      = ($urandom_range(0, 15) != 0);
      load        = ($urandom_range(0, 7) == 0);
      period_in   = W'($urandom_range(0, 12));
      duty_in     = W'($urandom_range(0, 14));
      prescale_in = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) mid_reset();
      else step();
    end
    load = 1'b0;
    run(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
